// File: rtl/dp_matrix_reader_if.sv
// Cell stream from the matrix reader to its sink: one cell per valid/ready
// handshake, carrying the counter value and its (x, y) coordinates.
interface dp_matrix_reader_if #(
  parameter int CNT_W = 9,
  parameter int IDX_W = 2
);

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;
  logic [IDX_W-1:0] out_x;
  logic [IDX_W-1:0] out_y;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_x,
    output out_y,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_x,
    input  out_y,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/dp_matrix_reader.sv
// Snapshots the I/Q density matrix on start, streams it cell by cell, and
// reports the total count and the peak cell once the whole matrix has gone out.
module dp_matrix_reader #(
  parameter  int MA_SIZE = 4,
  parameter  int CNT_W   = 9,
  localparam int IDX_W   = $clog2(MA_SIZE),
  localparam int SUM_W   = CNT_W + 2*IDX_W,
  localparam int N       = MA_SIZE*MA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*CNT_W-1:0]   matrix_in,
  input  logic                 start,
  input  logic                 clear_on_read,
  output logic                 acc_clear,
  dp_matrix_reader_if.master   stream,
  output logic                 busy,
  output logic                 done,
  output logic [SUM_W-1:0]     sum_total,
  output logic [CNT_W-1:0]     peak_value,
  output logic [2*IDX_W-1:0]   peak_idx
);

  localparam int KW = 2*IDX_W;
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] LAST_K = KW'(N-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  snap [N];
  logic [KW-1:0]     k;
  logic [SUM_W-1:0]  run_sum;
  logic [CNT_W-1:0]  run_peak;
  logic [KW-1:0]     run_idx;

  logic              handshake;
  logic [KW-1:0]     next_k;
  logic [SUM_W-1:0]  sum_next;
  logic              take_peak;
  logic [CNT_W-1:0]  peak_next;
  logic [KW-1:0]     idx_next;

  // out_data always mirrors snap[k] while streaming, so the registered output
  // doubles as the current cell for the running sum and strict-greater peak.
  always_comb begin
    handshake = stream.out_valid && stream.out_ready;
    next_k    = k + K_ONE;
    sum_next  = run_sum + {{(SUM_W-CNT_W){1'b0}}, stream.out_data};
    take_peak = stream.out_data > run_peak;
    peak_next = take_peak ? stream.out_data : run_peak;
    idx_next  = take_peak ? k : run_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      for (int i = 0; i < N; i++) begin
        snap[i] <= '0;
      end
      k                <= '0;
      run_sum          <= '0;
      run_peak         <= '0;
      run_idx          <= '0;
      acc_clear        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sum_total        <= '0;
      peak_value       <= '0;
      peak_idx         <= '0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_x     <= '0;
      stream.out_y     <= '0;
      stream.out_last  <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              snap[i] <= matrix_in[i*CNT_W +: CNT_W];
            end
            k                <= '0;
            run_sum          <= '0;
            run_peak         <= '0;
            run_idx          <= '0;
            acc_clear        <= clear_on_read;
            busy             <= 1'b1;
            stream.out_valid <= 1'b1;
            stream.out_data  <= matrix_in[0 +: CNT_W];
            stream.out_x     <= '0;
            stream.out_y     <= '0;
            stream.out_last  <= 1'b0;
            state            <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (handshake) begin
            run_sum  <= sum_next;
            run_peak <= peak_next;
            run_idx  <= idx_next;
            if (stream.out_last) begin
              // Results are published on the same edge that enters DONE.
              sum_total        <= sum_next;
              peak_value       <= peak_next;
              peak_idx         <= idx_next;
              done             <= 1'b1;
              stream.out_valid <= 1'b0;
              stream.out_data  <= '0;
              stream.out_x     <= '0;
              stream.out_y     <= '0;
              stream.out_last  <= 1'b0;
              state            <= S_DONE;
            end else begin
              k               <= next_k;
              stream.out_data <= snap[next_k];
              stream.out_x    <= next_k[IDX_W-1:0];
              stream.out_y    <= next_k[KW-1:IDX_W];
              stream.out_last <= (next_k == LAST_K);
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy             <= 1'b0;
          stream.out_valid <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_matrix_reader.sv
// Scoreboard bench for dp_matrix_reader: expected cells are queued when a read
// is launched and popped as the sink accepts them.
module tb_dp_matrix_reader;

  localparam int MA_SIZE = 4;
  localparam int CNT_W   = 9;
  localparam int IDX_W   = 2;
  localparam int SUM_W   = 13;
  localparam int N       = 16;

  typedef struct {
    logic [CNT_W-1:0] data;
    logic [IDX_W-1:0] x;
    logic [IDX_W-1:0] y;
    logic             last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*CNT_W-1:0] matrix_in;
  logic               start;
  logic               clear_on_read;
  logic               acc_clear;
  logic               busy;
  logic               done;
  logic [SUM_W-1:0]   sum_total;
  logic [CNT_W-1:0]   peak_value;
  logic [2*IDX_W-1:0] peak_idx;

  dp_matrix_reader_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) sif ();

  dp_matrix_reader #(.MA_SIZE(MA_SIZE), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .matrix_in     (matrix_in),
    .start         (start),
    .clear_on_read (clear_on_read),
    .acc_clear     (acc_clear),
    .stream        (sif),
    .busy          (busy),
    .done          (done),
    .sum_total     (sum_total),
    .peak_value    (peak_value),
    .peak_idx      (peak_idx)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned mat [N];
  beat_t       exp_q [$];
  int unsigned pend_sum, pend_peak, pend_idx;
  int          cyc;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the bench matrix onto matrix_in and queue the cells it must stream.
  task automatic prepRead();
    int unsigned s, pk, pi;
    s = 0; pk = 0; pi = 0;
    for (int i = 0; i < N; i++) begin
      beat_t b;
      matrix_in[i*CNT_W +: CNT_W] = CNT_W'(mat[i]);
      b.data = CNT_W'(mat[i]);
      b.x    = IDX_W'(i % MA_SIZE);
      b.y    = IDX_W'(i / MA_SIZE);
      b.last = (i == N-1);
      exp_q.push_back(b);
      s += mat[i];
      if (mat[i] > pk) begin
        pk = mat[i];
        pi = i;
      end
    end
    pend_sum = s; pend_peak = pk; pend_idx = pi;
  endtask

  task automatic applyStimulus(input logic clr);
    prepRead();
    clear_on_read = clr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("acc_clear_first", 32'(acc_clear), 32'(clr));
    checkOutput("valid_latency", 32'(sif.out_valid), 1);
    checkOutput("busy_stream", 32'(busy), 1);
  endtask

  // ready_mode 0: tied high; 1: 1-0-0-1 then random.
  task automatic streamBeats(input int ready_mode, input int max_beats, input bit pulse_mid, output int cycles);
    int c, beats;
    bit [3:0] pat;
    c = 0; beats = 0; pat = 4'b1001;
    while (exp_q.size() > 0 && beats < max_beats && c < 400) begin
      if (ready_mode == 0) sif.out_ready = 1'b1;
      else if (c < 8) sif.out_ready = pat[3 - (c % 4)];
      else sif.out_ready = 1'($urandom_range(0, 1));
      if (pulse_mid) start = (beats == 2 || beats == 9);
      if (c > 0) checkOutput("acc_clear_hold", 32'(acc_clear), 0);
      checkOutput("done_mid", 32'(done), 0);
      checkOutput("valid_mid", 32'(sif.out_valid), 1);
      if (sif.out_valid) begin
        checkOutput("data", 32'(sif.out_data), 32'(exp_q[0].data));
        checkOutput("x", 32'(sif.out_x), 32'(exp_q[0].x));
        checkOutput("y", 32'(sif.out_y), 32'(exp_q[0].y));
        checkOutput("last", 32'(sif.out_last), 32'(exp_q[0].last));
        if (sif.out_ready) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    if (pulse_mid) start = 1'b0;
    if (exp_q.size() > 0 && beats < max_beats) checkOutput("stream_timeout", 1, 0);
    cycles = c;
  endtask

  task automatic finishRead();
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("valid_after_last", 32'(sif.out_valid), 0);
    checkOutput("busy_done", 32'(busy), 1);
    checkOutput("sum_total", 32'(sum_total), pend_sum);
    checkOutput("peak_value", 32'(peak_value), pend_peak);
    checkOutput("peak_idx", 32'(peak_idx), pend_idx);
    @(posedge clk); #1;
    checkOutput("done_clear", 32'(done), 0);
    checkOutput("busy_idle", 32'(busy), 0);
    checkOutput("valid_idle", 32'(sif.out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_on_read = 1'b0;
    sif.out_ready = 1'b0;
    matrix_in = '0;
    #3;
    checkOutput("rst_valid", 32'(sif.out_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_acc_clear", 32'(acc_clear), 0);
    checkOutput("rst_sum", 32'(sum_total), 0);
    checkOutput("rst_peak", 32'(peak_value), 0);
    checkOutput("rst_idx", 32'(peak_idx), 0);
    checkOutput("rst_data", 32'(sif.out_data), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] ramp matrix, ready tied high");
    for (int i = 0; i < N; i++) mat[i] = i + 1;
    applyStimulus(1'b0);
    streamBeats(0, N, 1'b0, cyc);
    checkOutput("start_to_done", 32'(1 + cyc), 17);
    checkOutput("t1_sum", 32'(sum_total), 136);
    checkOutput("t1_idx", 32'(peak_idx), 15);
    finishRead();

    $display("[TB] ramp matrix, ready stalls");
    applyStimulus(1'b0);
    streamBeats(1, N, 1'b0, cyc);
    finishRead();

    $display("[TB] tied peaks");
    for (int i = 0; i < N; i++) mat[i] = 0;
    mat[5] = 511; mat[9] = 511;
    applyStimulus(1'b0);
    streamBeats(1, N, 1'b0, cyc);
    checkOutput("t3_idx", 32'(peak_idx), 5);
    checkOutput("t3_sum", 32'(sum_total), 1022);
    finishRead();

    $display("[TB] all-zero matrix");
    for (int i = 0; i < N; i++) mat[i] = 0;
    applyStimulus(1'b0);
    streamBeats(0, N, 1'b0, cyc);
    finishRead();

    $display("[TB] clear on read");
    for (int i = 0; i < N; i++) mat[i] = (i * 37 + 3) % 512;
    applyStimulus(1'b1);
    matrix_in = '0;
    streamBeats(0, N, 1'b0, cyc);
    finishRead();
    applyStimulus(1'b0);
    streamBeats(1, N, 1'b0, cyc);
    finishRead();

    $display("[TB] start while busy and held through done");
    for (int i = 0; i < N; i++) mat[i] = (i * 7) % 13 + 1;
    applyStimulus(1'b1);
    streamBeats(0, N, 1'b1, cyc);
    start = 1'b1;
    clear_on_read = 1'b0;
    finishRead();
    for (int i = 0; i < N; i++) mat[i] = 200 + i * 5;
    prepRead();
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("retrigger_valid", 32'(sif.out_valid), 1);
    checkOutput("retrigger_acc_clear", 32'(acc_clear), 0);
    streamBeats(0, N, 1'b0, cyc);
    finishRead();

    $display("[TB] reset mid-stream");
    for (int i = 0; i < N; i++) mat[i] = i * 3 + 2;
    applyStimulus(1'b0);
    streamBeats(0, 6, 1'b0, cyc);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(sif.out_valid), 0);
    checkOutput("rst_mid_busy", 32'(busy), 0);
    checkOutput("rst_mid_done", 32'(done), 0);
    checkOutput("rst_mid_sum", 32'(sum_total), 0);
    checkOutput("rst_mid_peak", 32'(peak_value), 0);
    exp_q.delete();
    #12;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_done", 32'(done), 0);
    for (int i = 0; i < N; i++) mat[i] = (i * 29 + 11) % 300;
    applyStimulus(1'b0);
    streamBeats(1, N, 1'b0, cyc);
    finishRead();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
